// File: rtl/sim_run_controller.sv
// sim_run_controller
//   Run controller for the pipelined core + cache-controller system. Starting from
//   one system clock, it holds the core in reset for a fixed number of cycles and
//   then releases it. It drives NCH programmable clock-enable channels, counts RUN
//   cycles, and ends the run when the cycle budget is used up. If the optional halt
//   detector is built in, a sustained halt indication also ends the run.
//
//   Optional feature macro: HALT_DETECT_EN
//     defined   -> HALT_HOLD consecutive RUN cycles with halt_i=1 end the run
//                  (timeout stays 0).
//     undefined -> halt_i is ignored; only the cycle budget ends a run.
//
//   Ports
//     clk        system clock
//     rst        asynchronous active-high reset
//     start      one-cycle pulse; begins a run from IDLE or DONE
//     div_cfg    channel i divide value at [i*DIV_W +: DIV_W], latched on start
//     halt_i     core halted indication (HALT_DETECT_EN builds only)
//     core_rst_n active-low reset to the pipeline/cache system (registered)
//     ce         per-channel clock enables
//     cycle_cnt  RUN cycles elapsed in the current/last run
//     running    high while in RUN
//     done       sticky, run finished
//     timeout    sticky, run ended by the cycle budget
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | after reset; core held in reset, enables off
//   HOLD   | core reset asserted for RST_HOLD cycles, all enables on
//   RUN    | core released, dividers active, cycle counter advancing
//   DONE   | run finished; system frozen (enables off), results held

module sim_run_controller #(
   parameter int NCH        = 2,
   parameter int DIV_W      = 4,
   parameter int RST_HOLD   = 5,
   parameter int CNT_W      = 20,
   parameter int MAX_CYCLES = 10000,
   parameter int HALT_HOLD  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NCH*DIV_W-1:0] div_cfg,
   input  logic                 halt_i,
   output logic                 core_rst_n,
   output logic [NCH-1:0]       ce,
   output logic [CNT_W-1:0]     cycle_cnt,
   output logic                 running,
   output logic                 done,
   output logic                 timeout
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [NCH*DIV_W-1:0] div_lat;
   logic [DIV_W-1:0]     ch_cnt [NCH];
   logic                 start_go;
   logic                 timeout_hit;
   logic                 halt_hit;

   assign start_go    = start && ((state == S_IDLE) || (state == S_DONE));
   assign timeout_hit = (state == S_RUN) && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
   assign running     = (state == S_RUN);

`ifdef HALT_DETECT_EN
   localparam int HALT_W = $clog2(HALT_HOLD + 1);
   logic [HALT_W-1:0] halt_cnt;

   // The run ends on the edge that completes HALT_HOLD consecutive halted cycles.
   assign halt_hit = (state == S_RUN) && halt_i && (halt_cnt == HALT_W'(HALT_HOLD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_cnt <= '0;
      end else if ((state == S_RUN) && halt_i) begin
         halt_cnt <= halt_cnt + 1'b1;
      end else begin
         halt_cnt <= '0;
      end
   end
`else
   logic halt_unused;
   assign halt_unused = halt_i;
   assign halt_hit    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_HOLD;
         S_HOLD:         if (hold_cnt == '0) state_nxt = S_RUN;
         S_RUN:          if (timeout_hit || halt_hit) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ce = '0;
      for (int i = 0; i < NCH; i++) begin
         ce[i] = (state == S_HOLD) || ((state == S_RUN) && (ch_cnt[i] == '0));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         core_rst_n <= 1'b0;
         hold_cnt   <= '0;
         div_lat    <= '0;
         cycle_cnt  <= '0;
         done       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         // Decoded from the next state so the release lands on the RUN entry edge.
         core_rst_n <= (state_nxt == S_RUN) || (state_nxt == S_DONE);
         if (start_go) begin
            div_lat   <= div_cfg;
            cycle_cnt <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= HOLD_W'(RST_HOLD - 1);
         end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         if (state == S_RUN) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (timeout_hit)          timeout <= 1'b1;
            if (timeout_hit || halt_hit) done <= 1'b1;
         end
      end
   end

   // Divider counters sit at 0 outside RUN so every channel fires on the first RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) ch_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if ((state == S_RUN) && (ch_cnt[i] != div_lat[i*DIV_W +: DIV_W])) begin
               ch_cnt[i] <= ch_cnt[i] + 1'b1;
            end else begin
               ch_cnt[i] <= '0;
            end
         end
      end
   end

endmodule
